// File: rtl/trans_pkg.sv
// trans_pkg: shared constants and types for the transaction arbiter.
//   DATA_W_DEFAULT  - default transaction word width
//   BIT_BLOCK_START - bit of the presented word that carries the block-start marker
//   TAG_W           - width of the requester index / in-flight tag
//   arb_state_e     - arbiter FSM states
package trans_pkg;

    localparam int unsigned DATA_W_DEFAULT  = 128;
    localparam int unsigned BIT_BLOCK_START = 9;
    localparam int unsigned TAG_W           = 3;

    typedef enum logic [1:0] {
        StIdle,
        StPresent,
        StBusy
    } arb_state_e;

endpackage

// File: rtl/trans_arbiter_if.sv
// trans_arbiter_if: arbiter <-> validator bus.
//   val_data      - word presented to the validator
//   val_valid     - validator request, held until val_ack
//   val_ack       - validator acceptance pulse
//   val_res_valid - validator approved-transaction pulse
//   val_res_data  - approved word
// Modports: master (arbiter side), slave (validator side).
interface trans_arbiter_if
    import trans_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) ();

    logic [DATA_W-1:0] val_data;
    logic              val_valid;
    logic              val_ack;
    logic              val_res_valid;
    logic [DATA_W-1:0] val_res_data;

    modport master (
        output val_data,
        output val_valid,
        input  val_ack,
        input  val_res_valid,
        input  val_res_data
    );

    modport slave (
        input  val_data,
        input  val_valid,
        output val_ack,
        output val_res_valid,
        output val_res_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req_i   - request vector
//   ptr_i   - index where the search starts (wraps modulo NUM_REQ)
//   grant_o - one-hot grant, zero when no request is set
module rr_arbiter
    import trans_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [TAG_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic found;

    // Walk offsets from the pointer; the first requesting index wins.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int off = 0; off < int'(NUM_REQ); off++) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!found && req_i[i] && ((int'(ptr_i) + off) % int'(NUM_REQ)) == i) begin
                    grant_o[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/trans_arbiter.sv
// trans_arbiter: round-robin arbiter feeding one validator with transaction words.
//   clk, rst_n      - clock, synchronous active-low reset
//   req_valid_i     - per-requester valid
//   req_data_i      - per-requester word, requester i at slice i
//   req_ready_o     - one-hot capture strobe (IDLE only)
//   blk_start_i     - marks the next presented word as a block start
//   val_bus         - validator bus (master modport)
//   res_valid_o     - approved-result pulse, res_data_o / res_id_o alongside
//   grant_cnt_o     - per-requester transfer counters (16 bits each)
//   accept_cnt_o    - approved-result counter
// Counters are built only with TRANS_ARB_STATS_EN defined; otherwise tied to zero.
module trans_arbiter
    import trans_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic                      blk_start_i,
    trans_arbiter_if.master           val_bus,
    output logic                      res_valid_o,
    output logic [DATA_W-1:0]         res_data_o,
    output logic [TAG_W-1:0]          res_id_o,
    output logic [NUM_REQ*16-1:0]     grant_cnt_o,
    output logic [15:0]               accept_cnt_o
);

    arb_state_e        state_q;
    logic [TAG_W-1:0]  ptr_q;
    logic [TAG_W-1:0]  tag_q;
    logic              blk_pend_q;
    logic              val_valid_q;
    logic [DATA_W-1:0] val_data_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic [TAG_W-1:0]  res_id_q;

    logic [NUM_REQ-1:0] grant;
    logic [TAG_W-1:0]   gnt_idx;
    logic [DATA_W-1:0]  sel_word;
    logic               transfer;
    logic               ack;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        gnt_idx  = '0;
        sel_word = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                gnt_idx  = TAG_W'(i);
                sel_word = req_data_i[i*DATA_W +: DATA_W];
            end
        end
        sel_word[BIT_BLOCK_START] = blk_pend_q;
    end

    // Gated by rst_n so the strobe is low during the reset cycle.
    assign req_ready_o = (rst_n && state_q == StIdle) ? grant : '0;
    assign transfer    = |(req_valid_i & req_ready_o);
    assign ack         = (state_q == StPresent) && val_bus.val_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            tag_q       <= '0;
            blk_pend_q  <= 1'b1;
            val_valid_q <= 1'b0;
            val_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            // Set wins over clear so a block start coinciding with ack is kept.
            if (blk_start_i) begin
                blk_pend_q <= 1'b1;
            end else if (ack) begin
                blk_pend_q <= 1'b0;
            end

            res_valid_q <= val_bus.val_res_valid;
            if (val_bus.val_res_valid) begin
                res_data_q <= val_bus.val_res_data;
                res_id_q   <= tag_q;
            end

            unique case (state_q)
                StIdle: begin
                    if (transfer) begin
                        val_data_q  <= sel_word;
                        tag_q       <= gnt_idx;
                        ptr_q       <= (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0
                                                                        : gnt_idx + TAG_W'(1);
                        val_valid_q <= 1'b1;
                        state_q     <= StPresent;
                    end
                end
                StPresent: begin
                    if (val_bus.val_ack) begin
                        val_valid_q <= 1'b0;
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign val_bus.val_valid = val_valid_q;
    assign val_bus.val_data  = val_data_q;
    assign res_valid_o       = res_valid_q;
    assign res_data_o        = res_data_q;
    assign res_id_o          = res_id_q;

`ifdef TRANS_ARB_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];
    logic [15:0] accept_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                grant_cnt_q[i] <= '0;
            end
            accept_cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (transfer && req_ready_o[i] && grant_cnt_q[i] != 16'hFFFF) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
            if (val_bus.val_res_valid && accept_cnt_q != 16'hFFFF) begin
                accept_cnt_q <= accept_cnt_q + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt_o[g*16 +: 16] = grant_cnt_q[g];
    end
    assign accept_cnt_o = accept_cnt_q;
`else
    assign grant_cnt_o  = '0;
    assign accept_cnt_o = '0;
`endif

endmodule

// File: tb/tb_trans_arbiter.sv
// tb_trans_arbiter: directed scoreboard bench for trans_arbiter.
// Stimulus pushes expected grants, presented words and results into queues; a monitor on the
// falling edge pops and compares whenever the DUT presents a grant, a word or a result.
module tb_trans_arbiter;
    import trans_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 128;

    localparam logic [DATA_W-1:0] W0 = 128'h0000_0000_0000_0000_0000_0000_0000_00A5;
    localparam logic [DATA_W-1:0] W1 = 128'h1111_1111_2222_2222_3333_3333_4444_4044;
    localparam logic [DATA_W-1:0] W2 = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_C2E7;
    localparam logic [DATA_W-1:0] W3 = 128'h8000_0000_0000_0000_0000_0000_0000_0301;
    localparam logic [DATA_W-1:0] D1 = 128'h5555_AAAA_5555_AAAA_0F0F_F0F0_1234_5678;
    localparam logic [DATA_W-1:0] D2 = 128'h0000_0001_0000_0002_0000_0003_0000_0004;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      blk_start;
    logic                      res_valid;
    logic [DATA_W-1:0]         res_data;
    logic [2:0]                res_id;
    logic [NUM_REQ*16-1:0]     grant_cnt;
    logic [15:0]               accept_cnt;

    int checks = 0;
    int errors = 0;

    logic [NUM_REQ-1:0] exp_grant[$];
    logic [DATA_W-1:0]  exp_val[$];
    logic [2:0]         exp_res_id[$];
    logic [DATA_W-1:0]  exp_res_data[$];

    always #5 clk = ~clk;

    trans_arbiter_if #(.DATA_W(DATA_W)) vbus ();

    trans_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .blk_start_i  (blk_start),
        .val_bus      (vbus.master),
        .res_valid_o  (res_valid),
        .res_data_o   (res_data),
        .res_id_o     (res_id),
        .grant_cnt_o  (grant_cnt),
        .accept_cnt_o (accept_cnt)
    );

    function automatic logic [DATA_W-1:0] with_b9(input logic [DATA_W-1:0] w, input logic b);
        logic [DATA_W-1:0] r;
        r = w;
        r[9] = b;
        return r;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_txn(input logic [NUM_REQ-1:0] g, input logic [DATA_W-1:0] w);
        exp_grant.push_back(g);
        exp_val.push_back(w);
    endtask

    task automatic wait_valid;
        int n;
        n = 0;
        while (!vbus.val_valid && n < 20) begin
            tick();
            n++;
        end
        if (!vbus.val_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: val_valid still low after %0d cycles", n);
        end
    endtask

    task automatic ack_after(input int n, input logic with_blk);
        repeat (n) tick();
        vbus.val_ack = 1'b1;
        blk_start    = with_blk;
        tick();
        vbus.val_ack = 1'b0;
        blk_start    = 1'b0;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        blk_start = 1'b0;
        vbus.val_ack       = 1'b0;
        vbus.val_res_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Monitor: grants, presented words (checked every valid cycle for stability) and results.
    logic              prev_vv = 1'b0;
    logic [DATA_W-1:0] cur_exp = '0;
    logic [NUM_REQ-1:0] g_pop;
    logic [2:0]         id_pop;
    logic [DATA_W-1:0]  d_pop;

    always @(negedge clk) begin
        if (req_ready != '0) begin
            if (exp_grant.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant: unexpected ready %b", req_ready);
            end else begin
                g_pop = exp_grant.pop_front();
                check("grant", DATA_W'(req_ready), DATA_W'(g_pop));
            end
        end
        if (vbus.val_valid) begin
            if (!prev_vv) begin
                if (exp_val.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL present: unexpected word %0h", vbus.val_data);
                end else begin
                    cur_exp = exp_val.pop_front();
                end
            end
            check("val_data", vbus.val_data, cur_exp);
            check("ready_in_present", DATA_W'(req_ready), '0);
        end
        prev_vv = vbus.val_valid;
        if (res_valid) begin
            if (exp_res_id.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result: unexpected id %0d data %0h", res_id, res_data);
            end else begin
                id_pop = exp_res_id.pop_front();
                d_pop  = exp_res_data.pop_front();
                check("res_id", DATA_W'(res_id), DATA_W'(id_pop));
                check("res_data", res_data, d_pop);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        req_data  = {W3, W2, W1, W0};
        blk_start = 1'b0;
        vbus.val_ack       = 1'b0;
        vbus.val_res_valid = 1'b0;
        vbus.val_res_data  = '0;

        do_reset();
        check("rst_val_valid", DATA_W'(vbus.val_valid), '0);
        check("rst_val_data", vbus.val_data, '0);
        check("rst_res_valid", DATA_W'(res_valid), '0);
        check("rst_res_data", res_data, '0);
        check("rst_res_id", DATA_W'(res_id), '0);
        check("rst_ready", DATA_W'(req_ready), '0);

        // No requests: stay idle.
        repeat (2) tick();
        check("idle_ready", DATA_W'(req_ready), '0);
        check("idle_val_valid", DATA_W'(vbus.val_valid), '0);

        // Single request right after reset, block-start bit set.
        expect_txn(4'b0001, with_b9(W0, 1'b1));
        req_valid = 4'b0001;
        tick();
        check("latency_valid", DATA_W'(vbus.val_valid), DATA_W'(1));
        req_valid = '0;
        ack_after(2, 1'b0);
        tick();

        // Round robin with all requesters valid.
        do_reset();
        expect_txn(4'b0001, with_b9(W0, 1'b1));
        expect_txn(4'b0010, with_b9(W1, 1'b0));
        expect_txn(4'b0100, with_b9(W2, 1'b0));
        expect_txn(4'b1000, with_b9(W3, 1'b0));
        expect_txn(4'b0001, with_b9(W0, 1'b0));
        req_valid = 4'b1111;
        repeat (5) begin
            wait_valid();
            ack_after(2, 1'b0);
        end
        req_valid = '0;
        tick();

        // Long stall on ack while every requester keeps asking.
        expect_txn(4'b0010, with_b9(W1, 1'b0));
        req_valid = 4'b1111;
        wait_valid();
        ack_after(50, 1'b0);
        req_valid = '0;
        tick();

        // Requester 2 owns two approved results; idle cycles in between carry no result.
        expect_txn(4'b0100, with_b9(W2, 1'b0));
        req_valid = 4'b0100;
        wait_valid();
        req_valid = '0;
        ack_after(1, 1'b0);
        exp_res_id.push_back(3'd2);
        exp_res_data.push_back(D1);
        vbus.val_res_valid = 1'b1;
        vbus.val_res_data  = D1;
        tick();
        vbus.val_res_valid = 1'b0;
        vbus.val_res_data  = W3;
        repeat (3) tick();
        exp_res_id.push_back(3'd2);
        exp_res_data.push_back(D2);
        vbus.val_res_valid = 1'b1;
        vbus.val_res_data  = D2;
        tick();
        vbus.val_res_valid = 1'b0;
        repeat (2) tick();

        // Block start coinciding with ack stays pending for the next word.
        expect_txn(4'b1000, with_b9(W3, 1'b0));
        req_valid = 4'b1000;
        wait_valid();
        req_valid = '0;
        ack_after(2, 1'b1);
        tick();
        expect_txn(4'b0001, with_b9(W0, 1'b1));
        req_valid = 4'b0001;
        wait_valid();
        req_valid = '0;
        ack_after(1, 1'b0);
        tick();

`ifdef TRANS_ARB_STATS_EN
        check("grant_cnt", DATA_W'(grant_cnt), DATA_W'({16'd2, 16'd2, 16'd2, 16'd3}));
        check("accept_cnt", DATA_W'(accept_cnt), DATA_W'(16'd2));
`else
        check("grant_cnt_tied", DATA_W'(grant_cnt), '0);
        check("accept_cnt_tied", DATA_W'(accept_cnt), '0);
`endif

        // Reset during PRESENT drops the word and restarts arbitration at requester 0.
        expect_txn(4'b0010, with_b9(W1, 1'b0));
        req_valid = 4'b1111;
        wait_valid();
        rst_n = 1'b0;
        tick();
        check("rst_present_valid", DATA_W'(vbus.val_valid), '0);
        check("rst_present_ready", DATA_W'(req_ready), '0);
        check("rst_grant_cnt", DATA_W'(grant_cnt), '0);
        check("rst_accept_cnt", DATA_W'(accept_cnt), '0);
        expect_txn(4'b0001, with_b9(W0, 1'b1));
        rst_n = 1'b1;
        wait_valid();
        req_valid = '0;
        ack_after(2, 1'b0);
        repeat (3) tick();

        check("grant_queue_empty", DATA_W'(exp_grant.size()), '0);
        check("val_queue_empty", DATA_W'(exp_val.size()), '0);
        check("res_queue_empty", DATA_W'(exp_res_id.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
